// File: rtl/token_stream_rom.sv
// token_stream_rom: writable token store streamed over valid/ready, with a combinational debug read port.
// Optional TOKEN_ROM_CHECKSUM_EN adds csum, the modular sum of accepted tokens.
module token_stream_rom #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 100,
    parameter int ADDR_W   = 7,
    parameter int END_CODE = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [DATA_W-1:0] tok_data,
    output logic              tok_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef TOKEN_ROM_CHECKSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic [DATA_W-1:0] rd_data
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
    localparam logic [DATA_W-1:0] END_TOK   = DATA_W'(END_CODE);
    localparam logic [DATA_W-1:0] IMG [8] = '{DATA_W'(1), DATA_W'(5), DATA_W'(22), DATA_W'(1),
                                              DATA_W'(0), DATA_W'(20), DATA_W'(9), DATA_W'(10)};
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    assign tok_valid = state == SEND;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign tok_last  = tok_valid && (tok_data == END_TOK || ptr == LAST_ADDR);
    assign rd_data   = {1'b0, rd_addr} < DEPTH_X ? mem[rd_addr] : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= i < 8 ? IMG[i[2:0]] : END_TOK;
        end else if (wr_en && {1'b0, wr_addr} < DEPTH_X) begin
            mem[wr_addr] <= wr_data;
        end
    end
    // Nonblocking reads of mem give read-before-write on a same-cycle write to ptr+1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            tok_data <= '0;
            err      <= 1'b0;
`ifdef TOKEN_ROM_CHECKSUM_EN
            csum     <= '0;
`endif
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
`ifdef TOKEN_ROM_CHECKSUM_EN
                    csum <= '0;
`endif
                    if ({1'b0, base_addr} < DEPTH_X) begin
                        ptr      <= base_addr;
                        tok_data <= mem[base_addr];
                        err      <= 1'b0;
                        state    <= SEND;
                    end else begin
                        err   <= 1'b1;
                        state <= DONE;
                    end
                end
                SEND: if (tok_ready) begin
`ifdef TOKEN_ROM_CHECKSUM_EN
                    csum <= csum + tok_data;
`endif
                    if (tok_last) begin
                        state <= DONE;
                    end else begin
                        ptr      <= ptr + 1'b1;
                        tok_data <= mem[ptr + 1'b1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_token_stream_rom.sv
// tb_token_stream_rom: randomized streams checked against an array/queue reference of the token store.
module tb_token_stream_rom;
    logic       clk = 0, rst_n = 0, start = 0, abort = 0, tok_ready = 0, wr_en = 0;
    logic [6:0] base_addr = 0, wr_addr = 0, rd_addr = 0;
    logic [7:0] wr_data = 0, tok_data, rd_data;
    logic       tok_valid, tok_last, busy, done, err;
`ifdef TOKEN_ROM_CHECKSUM_EN
    logic [7:0] csum;
`endif
    int total = 0, bad = 0;
    int ref_mem [100];
    int toks [$];

    token_stream_rom dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data), .tok_last(tok_last),
        .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr),
`ifdef TOKEN_ROM_CHECKSUM_EN
        .csum(csum),
`endif
        .rd_data(rd_data));

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        int img [8] = '{1, 5, 22, 1, 0, 20, 9, 10};
        for (int i = 0; i < 100; i++) ref_mem[i] = i < 8 ? img[i] : 10;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, tok_valid, 0);
        chk({tag, "_last"}, tok_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, tok_data, 0);
`ifdef TOKEN_ROM_CHECKSUM_EN
        chk({tag, "_csum"}, csum, 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; abort = 0; wr_en = 0; tok_ready = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        check_idle_zero("rst");
    endtask

    task automatic rd_check(input int a);
        rd_addr = 7'(a);
        #1;
        chk("rd_data", rd_data, a < 100 ? ref_mem[a] : 0);
    endtask

    task automatic write(input int a, input int d);
        wr_en = 1; wr_addr = 7'(a); wr_data = 8'(d);
        @(posedge clk); #1;
        wr_en = 0;
        if (a < 100) ref_mem[a] = d;
    endtask

    task automatic bad_start(input int b);
        start = 1; base_addr = 7'(b);
        @(posedge clk); #1;
        start = 0;
        chk("bad_err", err, 1);
        chk("bad_done", done, 1);
        chk("bad_valid", tok_valid, 0);
        chk("bad_busy", busy, 1);
        @(posedge clk); #1;
        chk("bad_done2", done, 0);
        chk("bad_busy2", busy, 0);
        chk("bad_err2", err, 1);
        chk("bad_valid2", tok_valid, 0);
    endtask

    // fw_ptr >= 0 forces one write of fw_data to fw_addr while that entry index is presented.
    task automatic stream(input int base, input int rdy_pct, input int wr_pct, input int abort_at,
                          input int fw_ptr, input int fw_addr, input int fw_data);
        int m_ptr, m_tok, cyc, wa, wd;
        bit fin, fw_done, wr, rdy, ab, last;
        logic [7:0] m_sum;
        start = 1; base_addr = 7'(base);
        @(posedge clk); #1;
        start = 0;
        m_ptr = base; m_tok = ref_mem[base]; m_sum = 0;
        fin = 0; fw_done = 0; cyc = 0; ab = 0;
        toks.delete();
        chk("err_clr", err, 0);
        while (!fin) begin
            last = m_tok == 10 || m_ptr == 99;
            chk("valid", tok_valid, 1);
            chk("data", tok_data, m_tok);
            chk("last", tok_last, last);
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            rd_check($urandom_range(0, 127));
            rdy = $urandom_range(0, 99) < rdy_pct;
            ab = toks.size() == abort_at;
            if (!fw_done && fw_ptr == m_ptr) begin
                wr = 1; wa = fw_addr; wd = fw_data; fw_done = 1;
            end else begin
                wr = $urandom_range(0, 99) < wr_pct;
                wa = $urandom_range(0, 110); wd = $urandom_range(0, 22);
            end
            tok_ready = rdy; abort = ab; wr_en = wr; wr_addr = 7'(wa); wr_data = 8'(wd);
            start = $urandom_range(0, 7) == 0; base_addr = 7'($urandom_range(0, 127));
            @(posedge clk); #1;
            tok_ready = 0; abort = 0; wr_en = 0; start = 0;
            if (ab) begin
                fin = 1;
            end else if (rdy) begin
                toks.push_back(m_tok);
                m_sum += 8'(m_tok);
                if (last) fin = 1;
                else begin
                    m_ptr++;
                    m_tok = ref_mem[m_ptr];
                end
            end
            if (wr && wa < 100) ref_mem[wa] = wd;
            if (++cyc > 3000) begin
                chk("timeout", cyc, 0);
                fin = 1;
            end
        end
        if (ab) begin
            chk("abort_valid", tok_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_busy", busy, 0);
            @(posedge clk); #1;
            chk("abort_done2", done, 0);
        end else begin
            chk("end_valid", tok_valid, 0);
            chk("end_done", done, 1);
            chk("end_busy", busy, 1);
            chk("end_last", tok_last, 0);
            @(posedge clk); #1;
            chk("end_done2", done, 0);
            chk("end_busy2", busy, 0);
`ifdef TOKEN_ROM_CHECKSUM_EN
            chk("csum", csum, m_sum);
`endif
        end
    endtask

    initial begin
        do_reset();
        for (int a = 0; a < 10; a++) rd_check(a);
        rd_check(100);
        rd_check(127);

        stream(0, 100, 0, -1, -1, 0, 0);
        chk("n_tok8", toks.size(), 8);
        chk("tok_last10", toks[7], 10);
`ifdef TOKEN_ROM_CHECKSUM_EN
        chk("csum68", csum, 68);
`endif
        stream(0, 50, 0, -1, -1, 0, 0);
        chk("n_tok8_bp", toks.size(), 8);

        stream(0, 100, 0, -1, 1, 3, 7);
        chk("tok4_written", toks[3], 7);
        write(99, 5);
        write(98, 4);
        write(110, 3);
        rd_check(110);
        rd_check(99);
        stream(98, 100, 0, -1, -1, 0, 0);
        chk("n_tok_tail", toks.size(), 2);
        chk("tail0", toks[0], 4);
        chk("tail1", toks[1], 5);

        bad_start(100);
        stream(0, 100, 0, -1, -1, 0, 0);
        stream(0, 100, 0, 2, -1, 0, 0);
        chk("abort_ntok", toks.size(), 2);

        write(0, 15);
        start = 1; base_addr = 0;
        @(posedge clk); #1;
        start = 0; tok_ready = 1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 0; start = 1; wr_en = 1; wr_addr = 1; wr_data = 99;
        @(posedge clk); #1;
        rst_n = 1; start = 0; wr_en = 0; tok_ready = 0;
        model_reset();
        check_idle_zero("midrst");
        for (int a = 0; a < 10; a++) rd_check(a);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) == 0) bad_start($urandom_range(100, 127));
            else stream($urandom_range(0, 99), $urandom_range(30, 100), 30,
                        $urandom_range(0, 4) == 0 ? $urandom_range(0, 3) : -1, -1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
